// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start bit (0), WIDTH data bits, stop bit (1).
// Presents each good word on A_par with a one-cycle Valid pulse; bad stop bits raise Frame_err.
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             Shift_en,
  input  logic             Serial_in,
  output logic [WIDTH-1:0] A_par,
  output logic             Valid,
  output logic             Frame_err,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_par;
  logic             r_valid;
  logic             r_ferr;
  logic             r_busy;

  state_t           w_state_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] w_sr_nx;
  logic [WIDTH-1:0] w_par_nx;
  logic             w_valid_nx;
  logic             w_ferr_nx;

  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_par   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sr    <= w_sr_nx;
      r_par   <= w_par_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
      r_busy  <= (w_state_nx != S_IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sr_nx    = r_sr;
    w_par_nx   = r_par;
    w_valid_nx = 1'b0;
    w_ferr_nx  = 1'b0;
    if (Shift_en) begin
      unique case (r_state)
        S_IDLE: begin
          if (!Serial_in) begin
            w_state_nx = S_DATA;
            w_cnt_nx   = '0;
          end
        end
        S_DATA: begin
          if (MSB_FIRST != 0) w_sr_nx = {r_sr[WIDTH-2:0], Serial_in};
          else                w_sr_nx = {Serial_in, r_sr[WIDTH-1:1]};
          // Count saturates at the last data bit instead of wrapping.
          if (r_cnt == LAST) w_state_nx = S_STOP;
          else               w_cnt_nx   = r_cnt + CW'(1);
        end
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (Serial_in) begin
            w_par_nx   = r_sr;
            w_valid_nx = 1'b1;
          end else begin
            w_ferr_nx  = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign A_par     = r_par;
  assign Valid     = r_valid;
  assign Frame_err = r_ferr;
  assign Busy      = r_busy;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: MSB-first and LSB-first instances share one line.
// Table rows give per-edge inputs and the outputs expected just after that edge.
module tb_serial_word_receiver;

  logic       CLK = 1'b0;
  logic       Clear_b;
  logic       Shift_en;
  logic       Serial_in;
  logic [3:0] par_m, par_l;
  logic       valid_m, valid_l, ferr_m, ferr_l, busy_m, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .CLK(CLK), .Clear_b(Clear_b), .Shift_en(Shift_en), .Serial_in(Serial_in),
    .A_par(par_m), .Valid(valid_m), .Frame_err(ferr_m), .Busy(busy_m)
  );

  serial_word_receiver #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .CLK(CLK), .Clear_b(Clear_b), .Shift_en(Shift_en), .Serial_in(Serial_in),
    .A_par(par_l), .Valid(valid_l), .Frame_err(ferr_l), .Busy(busy_l)
  );

  typedef struct {
    logic       en;
    logic       sin;
    logic [3:0] pm;
    logic [3:0] pl;
    logic       v;
    logic       fe;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic sin, logic [3:0] pm, logic [3:0] pl,
                              logic v, logic fe, logic b);
    vec_t r;
    r.en = en; r.sin = sin; r.pm = pm; r.pl = pl; r.v = v; r.fe = fe; r.b = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t r);
    chk({tag, " A_par msb"},     par_m,          r.pm);
    chk({tag, " A_par lsb"},     par_l,          r.pl);
    chk({tag, " Valid msb"},     {3'b0, valid_m}, {3'b0, r.v});
    chk({tag, " Valid lsb"},     {3'b0, valid_l}, {3'b0, r.v});
    chk({tag, " Frame_err msb"}, {3'b0, ferr_m},  {3'b0, r.fe});
    chk({tag, " Frame_err lsb"}, {3'b0, ferr_l},  {3'b0, r.fe});
    chk({tag, " Busy msb"},      {3'b0, busy_m},  {3'b0, r.b});
    chk({tag, " Busy lsb"},      {3'b0, busy_l},  {3'b0, r.b});
  endtask

  task automatic apply(input string tag, input vec_t r);
    @(negedge CLK);
    Shift_en  = r.en;
    Serial_in = r.sin;
    @(posedge CLK);
    #1;
    check_outs(tag, r);
  endtask

  initial begin
    // case 1: idle line
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 0, 0, 0));
    // case 2/3: 0,1,0,1,1,1 -> msb 1011, lsb 1101
    tbl.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 1, 0, 0));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 0));
    // case 4: 0,1,1,0,0,0 -> frame error, words kept, bad stop is not a start
    tbl.push_back(mk(1, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'hB, 4'hD, 0, 1, 0));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 0));
    // case 5: alternate enable, 0,1,1,1,0,1 -> msb 1110, lsb 0111; line toggled on disabled edges
    tbl.push_back(mk(0, 1, 4'hB, 4'hD, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'hB, 4'hD, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'hE, 4'h7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'hE, 4'h7, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'hE, 4'h7, 0, 0, 0));

    Clear_b   = 1'b0;
    Shift_en  = 1'b0;
    Serial_in = 1'b1;
    #30;
    check_outs("reset", mk(0, 1, 4'h0, 4'h0, 0, 0, 0));
    #10 Clear_b = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("row%0d", i), tbl[i]);

    // case 6: async clear after two data bits, then back-to-back frames
    apply("c6 start", mk(1, 0, 4'hE, 4'h7, 0, 0, 1));
    apply("c6 d0",    mk(1, 1, 4'hE, 4'h7, 0, 0, 1));
    apply("c6 d1",    mk(1, 1, 4'hE, 4'h7, 0, 0, 1));
    @(negedge CLK);
    #2 Clear_b = 1'b0;
    #1 check_outs("c6 async", mk(1, 1, 4'h0, 4'h0, 0, 0, 0));
    @(posedge CLK);
    #1 check_outs("c6 held", mk(1, 1, 4'h0, 4'h0, 0, 0, 0));
    Clear_b = 1'b1;
    // line at 1 after release: partial frame must not resume
    apply("c6 idle",  mk(1, 1, 4'h0, 4'h0, 0, 0, 0));
    apply("c6a st",   mk(1, 0, 4'h0, 4'h0, 0, 0, 1));
    apply("c6a d0",   mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    apply("c6a d1",   mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    apply("c6a d2",   mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    apply("c6a d3",   mk(1, 1, 4'h0, 4'h0, 0, 0, 1));
    apply("c6a sp",   mk(1, 1, 4'hF, 4'hF, 1, 0, 0));
    apply("c6b st",   mk(1, 0, 4'hF, 4'hF, 0, 0, 1));
    apply("c6b d0",   mk(1, 0, 4'hF, 4'hF, 0, 0, 1));
    apply("c6b d1",   mk(1, 0, 4'hF, 4'hF, 0, 0, 1));
    apply("c6b d2",   mk(1, 0, 4'hF, 4'hF, 0, 0, 1));
    apply("c6b d3",   mk(1, 1, 4'hF, 4'hF, 0, 0, 1));
    apply("c6b sp",   mk(1, 1, 4'h1, 4'h8, 1, 0, 0));
    apply("c6b after", mk(1, 1, 4'h1, 4'h8, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
